// File: rtl/uop_instr_queue.sv
// Multi-wide in-order uop queue between decode and rename/dispatch.
// Variable-width enqueue, partial dequeue ack, optional branch-split groups, single-cycle flush.

package uop_pkg;

    typedef enum logic [3:0] {
        UOP_NOP,
        UOP_ADD,
        UOP_SUB,
        UOP_AND,
        UOP_OR,
        UOP_XOR,
        UOP_LOAD,
        UOP_STORE,
        UOP_BRANCH
    } uop_code_e;

    typedef struct packed {
        uop_code_e   uopcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } uop_insn;

endpackage

module uop_instr_queue
    import uop_pkg::*;
#(
    parameter int DEPTH        = 32,
    parameter int ENQ_WIDTH    = 4,
    parameter int DEQ_WIDTH    = 4,
    parameter int BRANCH_SPLIT = 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           flush_in,
    input  logic [$clog2(ENQ_WIDTH+1)-1:0] enq_count_in,
    input  uop_insn [ENQ_WIDTH-1:0]        enq_uops_in,
    output logic                           enq_ready_out,
    output uop_insn [DEQ_WIDTH-1:0]        deq_uops_out,
    output logic [DEQ_WIDTH-1:0]           deq_valid_out,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0] deq_count_in,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy_out,
    output logic                           empty_out,
    output logic                           full_out
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH+1);
    localparam int ECNT_W = $clog2(ENQ_WIDTH+1);
    localparam int DCNT_W = $clog2(DEQ_WIDTH+1);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    uop_insn           mem_q [DEPTH];

    logic [ECNT_W-1:0] enq_req;
    logic [ECNT_W-1:0] enq_n;
    logic              enq_fire;
    logic [DCNT_W-1:0] valid_cnt;
    logic [DCNT_W-1:0] deq_m;

    // Status depends only on registered occupancy, never on same-cycle handshakes.
    assign enq_ready_out = (occ_q <= OCC_W'(DEPTH - ENQ_WIDTH));
    assign empty_out     = (occ_q == '0);
    assign full_out      = (occ_q == OCC_W'(DEPTH));
    assign occupancy_out = occ_q;

    always_comb begin : deq_present
        logic    cut;
        uop_insn lane;
        // NOTE: every signal driven here gets a default first, so no latches are inferred.
        cut           = 1'b0;
        deq_valid_out = '0;
        valid_cnt     = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            lane            = mem_q[head_q + PTR_W'(i)];
            deq_uops_out[i] = lane;
            if ((occ_q > OCC_W'(i)) && !cut) begin
                deq_valid_out[i] = 1'b1;
                valid_cnt        = valid_cnt + DCNT_W'(1);
                if ((BRANCH_SPLIT != 0) && (lane.uopcode == UOP_BRANCH)) begin
                    cut = 1'b1;
                end
            end
        end
    end

    always_comb begin : next_state
        enq_req  = (enq_count_in > ECNT_W'(ENQ_WIDTH)) ? ECNT_W'(ENQ_WIDTH) : enq_count_in;
        enq_fire = enq_ready_out && (enq_req != '0);
        enq_n    = enq_fire ? enq_req : '0;
        deq_m    = (deq_count_in < valid_cnt) ? deq_count_in : valid_cnt;

        head_d = head_q + PTR_W'(deq_m);
        tail_d = tail_q + PTR_W'(enq_n);
        occ_d  = occ_q + OCC_W'(enq_n) - OCC_W'(deq_m);

        // Flush wins over any same-cycle enqueue or dequeue.
        if (flush_in) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and occupancy alone decide which entries are live.
    always_ff @(posedge clk_in) begin
        if (enq_fire && !flush_in) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (ECNT_W'(i) < enq_n) begin
                    mem_q[tail_q + PTR_W'(i)] <= enq_uops_in[i];
                end
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: tb/tb_uop_instr_queue.sv
// Directed bench for uop_instr_queue: stimulus pushes expected uops into a scoreboard,
// a negedge monitor pops and compares every lane the queue actually retires.

module tb_uop_instr_queue;
    import uop_pkg::*;

    localparam int DEPTH = 32;
    localparam int ENQ_W = 4;
    localparam int DEQ_W = 4;

    logic                 clk_in    = 1'b0;
    logic                 rst_in    = 1'b1;
    logic                 flush_in  = 1'b0;
    logic [2:0]           enq_count = '0;
    uop_insn [ENQ_W-1:0]  enq_uops  = '0;
    logic [2:0]           deq_count = '0;

    logic                 enq_ready, empty, full;
    uop_insn [DEQ_W-1:0]  deq_uops;
    logic [DEQ_W-1:0]     deq_valid;
    logic [5:0]           occ;

    logic                 ns_ready, ns_empty, ns_full;
    uop_insn [DEQ_W-1:0]  ns_uops;
    logic [DEQ_W-1:0]     ns_valid;
    logic [5:0]           ns_occ;

    int checks = 0;
    int errors = 0;
    uop_insn exp_q[$];

    uop_instr_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_W), .DEQ_WIDTH(DEQ_W), .BRANCH_SPLIT(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .enq_count_in(enq_count), .enq_uops_in(enq_uops), .enq_ready_out(enq_ready),
        .deq_uops_out(deq_uops), .deq_valid_out(deq_valid), .deq_count_in(deq_count),
        .occupancy_out(occ), .empty_out(empty), .full_out(full)
    );

    // Same stimulus, no branch split: only its valid mask and occupancy are checked.
    uop_instr_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_W), .DEQ_WIDTH(DEQ_W), .BRANCH_SPLIT(0)) dut_ns (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .enq_count_in(enq_count), .enq_uops_in(enq_uops), .enq_ready_out(ns_ready),
        .deq_uops_out(ns_uops), .deq_valid_out(ns_valid), .deq_count_in(deq_count),
        .occupancy_out(ns_occ), .empty_out(ns_empty), .full_out(ns_full)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic uop_insn mk(input uop_code_e c, input logic [31:0] imm);
        uop_insn u;
        u         = '0;
        u.uopcode = c;
        u.rd      = imm[4:0];
        u.imm     = imm;
        return u;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        enq_count = '0;
        deq_count = '0;
        flush_in  = 1'b0;
    endtask

    task automatic push_lanes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(enq_uops[i]);
    endtask

    task automatic load4(input uop_code_e c, input logic [31:0] base);
        for (int i = 0; i < ENQ_W; i++) enq_uops[i] = mk(c, base + 32'(i));
    endtask

    // Monitor: compares every lane retired at the coming edge against the scoreboard.
    always @(negedge clk_in) begin : monitor
        int avail;
        int m;
        if (!rst_in && !flush_in) begin
            avail = 0;
            for (int i = 0; i < DEQ_W; i++) if (deq_valid[i]) avail++;
            m = (int'(deq_count) < avail) ? int'(deq_count) : avail;
            for (int i = 0; i < m; i++) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow lane %0d actual=%h required=none", i, deq_uops[i]);
                end else begin
                    check($sformatf("deq_lane%0d", i), deq_uops[i], exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        idle();
        #12 rst_in = 1'b0;
        check("init_empty", empty, 1'b1);
        check("init_ready", enq_ready, 1'b1);
        step();

        // Reset mid-stream with occupancy 7.
        load4(UOP_ADD, 32'h10); enq_count = 3'd4; push_lanes(4); step();
        load4(UOP_OR,  32'h14); enq_count = 3'd3; push_lanes(3); step();
        idle();
        check("pre_rst_occ", occ, 6'd7);
        check("pre_rst_valid", deq_valid, 4'b1111);
        #2 rst_in = 1'b1;
        #1;
        check("rst_occ", occ, 6'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_ready", enq_ready, 1'b1);
        check("rst_valid", deq_valid, 4'b0000);
        check("rst_full", full, 1'b0);
        exp_q.delete();
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Fill to ready drop and full.
        for (int c = 0; c < 7; c++) begin
            load4(UOP_ADD, 32'h200 + 32'(4 * c)); enq_count = 3'd4; push_lanes(4); step();
        end
        idle();
        check("fill28_occ", occ, 6'd28);
        check("fill28_ready", enq_ready, 1'b1);
        check("fill28_full", full, 1'b0);
        load4(UOP_SUB, 32'h21C); enq_count = 3'd4; push_lanes(4); step();
        idle();
        check("fill32_occ", occ, 6'd32);
        check("fill32_full", full, 1'b1);
        check("fill32_ready", enq_ready, 1'b0);
        check("fill32_valid", deq_valid, 4'b1111);
        load4(UOP_XOR, 32'h300); enq_count = 3'd3; step();
        idle();
        check("full_ignore_occ", occ, 6'd32);
        deq_count = 3'd4;
        for (int c = 0; c < 8; c++) step();
        idle();
        check("drain_occ", occ, 6'd0);
        check("drain_empty", empty, 1'b1);

        // Partial dequeue with over-ack clamp.
        enq_uops[0] = mk(UOP_ADD, 32'h31);
        enq_uops[1] = mk(UOP_SUB, 32'h32);
        enq_uops[2] = mk(UOP_AND, 32'h33);
        enq_count = 3'd3; push_lanes(3); step();
        idle();
        check("part_valid", deq_valid, 4'b0111);
        check("part_occ", occ, 6'd3);
        deq_count = 3'd4; step();
        idle();
        check("clamp_occ", occ, 6'd0);
        check("clamp_valid", deq_valid, 4'b0000);

        // Branch split.
        flush_in = 1'b1; step(); idle(); exp_q.delete();
        enq_uops[0] = mk(UOP_ADD,    32'h40);
        enq_uops[1] = mk(UOP_BRANCH, 32'h41);
        enq_uops[2] = mk(UOP_SUB,    32'h42);
        enq_uops[3] = mk(UOP_XOR,    32'h43);
        enq_count = 3'd4; push_lanes(4); step();
        idle();
        check("split_valid", deq_valid, 4'b0011);
        check("nosplit_valid", ns_valid, 4'b1111);
        check("nosplit_occ", ns_occ, 6'd4);
        deq_count = 3'd2; step();
        idle();
        check("split2_valid", deq_valid, 4'b0011);
        check("split2_lane0_code", deq_uops[0].uopcode, UOP_SUB);
        check("split2_lane1_imm", deq_uops[1].imm, 32'h43);
        deq_count = 3'd4; step();
        idle();
        check("split_drain_occ", occ, 6'd0);
        enq_uops[0] = mk(UOP_BRANCH, 32'h44);
        enq_uops[1] = mk(UOP_ADD,    32'h45);
        enq_count = 3'd2; push_lanes(2); step();
        idle();
        check("br_lane0_valid", deq_valid, 4'b0001);
        deq_count = 3'd4; step();
        idle();
        check("br_after_valid", deq_valid, 4'b0001);
        check("br_after_occ", occ, 6'd1);
        deq_count = 3'd4; step();
        idle();
        check("br_drain_occ", occ, 6'd0);

        // Advance head/tail to 30 with simultaneous enqueue and dequeue, then wrap.
        flush_in = 1'b1; step(); idle(); exp_q.delete();
        for (int c = 0; c < 7; c++) begin
            load4(UOP_ADD, 32'h500 + 32'(4 * c)); enq_count = 3'd4; push_lanes(4);
            deq_count = 3'd4; step();
        end
        load4(UOP_AND, 32'h51C); enq_count = 3'd2; push_lanes(2); deq_count = 3'd4; step();
        enq_count = '0; deq_count = 3'd4; step();
        idle();
        check("pre_wrap_occ", occ, 6'd0);
        check("pre_wrap_empty", empty, 1'b1);
        load4(UOP_XOR, 32'hA0); enq_count = 3'd4; push_lanes(4); step();
        idle();
        check("wrap_valid", deq_valid, 4'b1111);
        check("wrap_occ", occ, 6'd4);
        for (int i = 0; i < DEQ_W; i++)
            check($sformatf("wrap_lane%0d_imm", i), deq_uops[i].imm, 32'hA0 + 32'(i));
        deq_count = 3'd4; step();
        idle();
        check("wrap_drain_occ", occ, 6'd0);

        // Enqueue count clamp, then flush priority at occupancy 5.
        load4(UOP_ADD, 32'h600); enq_count = 3'd7; push_lanes(4); step();
        enq_uops[0] = mk(UOP_SUB, 32'h604); enq_count = 3'd1; push_lanes(1); step();
        idle();
        check("enq_clamp_occ", occ, 6'd5);
        load4(UOP_OR, 32'h700); enq_count = 3'd4; deq_count = 3'd2; flush_in = 1'b1; step();
        idle();
        exp_q.delete();
        check("flush_occ", occ, 6'd0);
        check("flush_empty", empty, 1'b1);
        check("flush_valid", deq_valid, 4'b0000);
        check("flush_ready", enq_ready, 1'b1);
        step();
        check("flush_no_entry_occ", occ, 6'd0);
        check("flush_no_entry_valid", deq_valid, 4'b0000);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
